// File: rtl/sum_rest_pkg.sv
// Shared constants for the sum_rest registered adder/subtractor.
package sum_rest_pkg;

    localparam int SR_WIDTH = 4;

    localparam logic SR_OP_ADD = 1'b1;
    localparam logic SR_OP_SUB = 1'b0;

endpackage : sum_rest_pkg

// File: rtl/sum_rest_full_adder.sv
// One-bit full adder cell; chained by sum_rest into a ripple-carry adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule : full_adder

// File: rtl/sum_rest.sv
// Registered unsigned add/subtract: a single ripple chain serves both modes,
// subtraction being ent1 + ~ent2 + 1 over WIDTH+1 bits.
module sum_rest
    import sum_rest_pkg::*;
#(
    parameter int WIDTH = SR_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sel,
    input  logic [WIDTH-1:0] ent1,
    input  logic [WIDTH-1:0] ent2,
    output logic [WIDTH:0]   sal
);

    logic             sub_mode;
    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   b_ext;
    logic [WIDTH:0]   b_mod;
    logic [WIDTH:0]   sal_next;
    logic [WIDTH+1:0] carry;
    logic [WIDTH:0]   sal_reg;
    logic             unused_carry;

    assign sub_mode = (sel == SR_OP_SUB);

    // Zero-extend before inverting so the borrow lands in the extra MSB.
    assign a_ext    = {1'b0, ent1};
    assign b_ext    = {1'b0, ent2};
    assign b_mod    = b_ext ^ {(WIDTH+1){sub_mode}};
    assign carry[0] = sub_mode;

    generate
        for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_ripple
            full_adder u_fa (
                .a    (a_ext[gi]),
                .b    (b_mod[gi]),
                .cin  (carry[gi]),
                .s    (sal_next[gi]),
                .cout (carry[gi+1])
            );
        end
    endgenerate

    // Results wrap modulo 2**(WIDTH+1); the final carry has no consumer.
    assign unused_carry = carry[WIDTH+1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sal_reg <= '0;
        end else begin
            sal_reg <= sal_next;
        end
    end

    assign sal = sal_reg;

endmodule : sum_rest

// File: tb/tb_sum_rest.sv
// Directed and exhaustive checks of sum_rest: reset, add/sub sweeps, borrow, mode toggling.
module tb_sum_rest;

    logic       clk;
    logic       rst_n;
    logic       sel;
    logic [3:0] ent1;
    logic [3:0] ent2;
    logic [4:0] sal;

    int tests_run;
    int tests_failed;

    sum_rest #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sel   (sel),
        .ent1  (ent1),
        .ent2  (ent2),
        .sal   (sal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [4:0] exp);
        tests_run++;
        assert (sal === exp) else begin
            tests_failed++;
            $error("FAIL %s: sal=%0d expected %0d", tag, sal, exp);
        end
        $display("[TB] %s sel=%0b ent1=%0d ent2=%0d sal=%0d exp=%0d", tag, sel, ent1, ent2, sal, exp);
    endtask

    // Apply operands, wait one rising edge, then check 1 ns after it.
    task automatic step(input string tag, input logic s, input logic [3:0] a,
                        input logic [3:0] b, input logic [4:0] exp);
        sel  = s;
        ent1 = a;
        ent2 = b;
        @(posedge clk);
        #1;
        check(tag, exp);
    endtask

    initial begin
        logic [4:0] exp_v;
        logic [4:0] prev_v;
        tests_run    = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        sel   = 1'b1;
        ent1  = 4'd0;
        ent2  = 4'd0;

        #2;
        check("reset_initial", 5'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset mid-stream.
        step("pre_reset_9p9", 1'b1, 4'd9, 4'd9, 5'd18);
        rst_n = 1'b0;
        #1;
        check("async_reset_immediate", 5'd0);
        sel = 1'b1; ent1 = 4'd15; ent2 = 4'd15;
        @(posedge clk);
        #1;
        check("reset_held_over_edge", 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_reset_3p4", 1'b1, 4'd3, 4'd4, 5'd7);

        // Add sweep: i + (15-2i) = 15-i.
        for (int i = 0; i < 8; i++) begin
            step("add_sweep", 1'b1, 4'(i), 4'(15 - 2 * i), 5'(15 - i));
        end
        step("add_15p15_carry", 1'b1, 4'd15, 4'd15, 5'd30);
        step("add_0p0", 1'b1, 4'd0, 4'd0, 5'd0);

        // Subtract sweep: (15-i) - i = 15-2i.
        for (int i = 0; i < 8; i++) begin
            step("sub_sweep", 1'b0, 4'(15 - i), 4'(i), 5'(15 - 2 * i));
        end

        // Borrow cases.
        step("borrow_3m5", 1'b0, 4'd3, 4'd5, 5'b11110);
        step("borrow_0m15", 1'b0, 4'd0, 4'd15, 5'b10001);
        step("sub_0m0", 1'b0, 4'd0, 4'd0, 5'd0);
        step("sub_15m0", 1'b0, 4'd15, 4'd0, 5'd15);

        // Mode switch: output must hold the old value until the edge.
        prev_v = 5'd15;
        for (int k = 0; k < 6; k++) begin
            sel  = (k % 2 == 0) ? 1'b1 : 1'b0;
            ent1 = 4'd9;
            ent2 = 4'd4;
            exp_v = sel ? 5'd13 : 5'd5;
            #2;
            check("toggle_hold", prev_v);
            @(posedge clk);
            #1;
            check("toggle_capture", exp_v);
            prev_v = exp_v;
        end

        // Exhaustive sweep against the arithmetic reference.
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    exp_v = (s == 1) ? 5'(a + b) : 5'((a - b) & 31);
                    step("exhaustive", 1'(s), 4'(a), 4'(b), exp_v);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_sum_rest
